// File: rtl/mem_read_arbiter_if.sv
// Bundle of the requester, memory read port and status signals of mem_read_arbiter.
// slave = arbiter side; master = core requesters plus memory model side.
interface mem_read_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          arb_en;
   logic          req0;
   logic [AW-1:0] addr0;
   logic          ack0;
   logic [DW-1:0] rdata0;
   logic          req1;
   logic [AW-1:0] addr1;
   logic          ack1;
   logic [DW-1:0] rdata1;
   logic          m_rrdy;
   logic [AW-1:0] m_raddr;
   logic          m_rvld;
   logic [DW-1:0] m_rdata;
   logic          busy;

   modport slave (
      input  arb_en, req0, addr0, req1, addr1, m_rvld, m_rdata,
      output ack0, rdata0, ack1, rdata1, m_rrdy, m_raddr, busy
   );

   modport master (
      output arb_en, req0, addr0, req1, addr1, m_rvld, m_rdata,
      input  ack0, rdata0, ack1, rdata1, m_rrdy, m_raddr, busy
   );
endinterface

// File: rtl/mem_read_arbiter.sv
// Shares one memory read port between instruction fetch (port 0) and loads (port 1).
// Define MEM_ARB_RR_EN for round-robin tie-breaking; default build is fixed priority, port 1 wins.
//
// state | meaning
// IDLE  | no read outstanding; a new grant may be issued when arb_en
// BUSY  | m_rrdy held with the winner's address, waiting for m_rvld
module mem_read_arbiter #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic              clk,
   input  logic              rstn,
   mem_read_arbiter_if.slave bus
);
   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t        state;
   state_t        state_d;
   logic          grant;
   logic          grant_d;
   logic          last_grant;
   logic          last_grant_d;
   logic          rrdy;
   logic          rrdy_d;
   logic          pick;
   logic [AW-1:0] raddr;
   logic [AW-1:0] raddr_d;
   logic [DW-1:0] rdata;

`ifdef MEM_ARB_RR_EN
   always_comb begin
      pick = bus.req1;
      if (bus.req0 && bus.req1)
         pick = ~last_grant;
   end
`else
   // last_grant is still tracked so both builds share one state register set
   logic unused_last_grant;
   assign unused_last_grant = last_grant;

   always_comb begin
      pick = bus.req1;
   end
`endif

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state      <= IDLE;
         grant      <= 1'b0;
         last_grant <= 1'b1;
         rrdy       <= 1'b0;
         raddr      <= '0;
      end else begin
         state      <= state_d;
         grant      <= grant_d;
         last_grant <= last_grant_d;
         rrdy       <= rrdy_d;
         raddr      <= raddr_d;
      end
   end

   always_comb begin
      state_d      = state;
      grant_d      = grant;
      last_grant_d = last_grant;
      rrdy_d       = rrdy;
      raddr_d      = raddr;
      case (state)
         IDLE: begin
            if (bus.arb_en && (bus.req0 || bus.req1)) begin
               state_d      = BUSY;
               grant_d      = pick;
               last_grant_d = pick;
               rrdy_d       = 1'b1;
               raddr_d      = pick ? bus.addr1 : bus.addr0;
            end
         end
         BUSY: begin
            if (bus.m_rvld) begin
               state_d = IDLE;
               rrdy_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // acks are gated by BUSY so a stray m_rvld while idle is never forwarded
   assign bus.busy    = (state == BUSY);
   assign bus.ack0    = (state == BUSY) & bus.m_rvld & ~grant;
   assign bus.ack1    = (state == BUSY) & bus.m_rvld & grant;
   assign rdata       = bus.m_rdata;
   assign bus.rdata0  = rdata;
   assign bus.rdata1  = rdata;
   assign bus.m_rrdy  = rrdy;
   assign bus.m_raddr = raddr;
endmodule
